plate_char_buffer: RTL and testbench
====================================

# plate_char_buffer

Collects the character codes emitted by the license-plate character recognizer into an ordered plate string. Sits directly downstream of the recognizer and consumes its `ReadCh`/`CharCheck`/`done` outputs. After the plate is complete, it streams the string out over a valid/ready handshake for display or UART formatting. It also flags empty, over-length and (optionally) too-short plates.

## Interface
Parameters:
- `MAX_CHARS`, 10 — buffer depth in characters (2..15).
- `CH_W`, 6 — character code width; must match recognizer `ReadCh`.
- `MIN_CHARS`, 4 — minimum accepted plate length (used only with `PLATE_LEN_CHECK_EN`).

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — synchronous, active-low reset.
- `start` in 1 — new-plate pulse; same pulse that starts the recognizer.
- `ch_in` in CH_W — character code from recognizer.
- `ch_valid` in 1 — one-cycle strobe; `ch_in` valid.
- `rec_done` in 1 — recognizer finished the plate.
- `out_ch` out CH_W — streamed character.
- `out_valid` out 1 — `out_ch` valid.
- `out_ready` in 1 — consumer accepts `out_ch`.
- `out_last` out 1 — marks the final character of the plate.
- `plate_len` out 4 — number of stored characters.
- `plate_err` out 1 — one-cycle pulse: plate rejected.
- `overflow` out 1 — sticky per plate: more than MAX_CHARS valid characters arrived.
- `busy` out 1 — high in any state except IDLE.

## Operation
- Valid codes are 0..35 (0–9 then A–Z). Codes ≥36 are non-characters: dropped, not stored, not counted.
- States: IDLE, COLLECT, CHECK, READOUT.
- IDLE → COLLECT on `start`. This clears `plate_len`, `overflow` and the write pointer.
- COLLECT: each cycle with `ch_valid`=1 and a valid code writes `ch_in` at `buf[plate_len]` and increments `plate_len`.
  - When `plate_len`==MAX_CHARS, further valid characters are discarded and `overflow` is set to 1.
- COLLECT → CHECK on `rec_done`. If `ch_valid` and `rec_done` are high in the same cycle, the character is stored first.
- CHECK takes one cycle:
  - `plate_len`==0 → pulse `plate_err`, go to IDLE.
  - `overflow`=1 → pulse `plate_err`, go to IDLE.
  - Otherwise → READOUT with read pointer 0.
- READOUT:
  - `out_valid`=1 and `out_ch`=`buf[rd_ptr]`.
  - `out_last`=1 when `rd_ptr`==`plate_len`−1.
  - The read pointer advances on each cycle with `out_valid`&&`out_ready`.
  - The transfer with `out_last` returns the block to IDLE.
  - `plate_len` holds its value until the next `start`.
- `start` in COLLECT, CHECK or READOUT aborts the current plate: the buffer is cleared and the block enters COLLECT. No `plate_err` is raised; `out_valid` drops the following cycle.
- `ch_valid` and `rec_done` are ignored in IDLE and READOUT. `rec_done` is ignored in CHECK.
- Pointer and length arithmetic is 4-bit unsigned with no wrap: counters saturate at MAX_CHARS.

## Timing
- Reset (`rst`=0 at a clock edge) values:
  - state = IDLE
  - `out_valid`=0, `out_last`=0, `out_ch`=0
  - `plate_len`=0, `plate_err`=0, `overflow`=0, `busy`=0
- Reset mid-operation discards the plate with no error pulse.
- `start` sampled at edge N → `busy`=1 after edge N. Characters are accepted from the cycle after `start`.
- Character strobe at edge N → `plate_len` updated after edge N.
- `rec_done` at edge N → CHECK after edge N. After edge N+1, either `out_valid`=1 or `plate_err`=1 (for exactly one cycle).
- `out_ch`, `out_last` and `out_valid` are registered. They are held stable while `out_valid`=1 and `out_ready`=0.
- Back-to-back transfers sustain one character per cycle.
- After the last transfer at edge M, `out_valid`=0 and `busy`=0 after edge M.

## Configuration
- `PLATE_LEN_CHECK_EN` defined: CHECK also rejects plates with 0 < `plate_len` < MIN_CHARS (pulse `plate_err`, go to IDLE, no readout).
- Not defined: any plate with 1..MAX_CHARS characters and no overflow is streamed; MIN_CHARS is unused.

## Test plan
- Normal plate: `start`; strobe codes 10,11,3,4,5,6; `rec_done`; `out_ready`=1 → `out_ch` sequence 10,11,3,4,5,6 on consecutive cycles, `out_last` on 6, `plate_len`=6, `plate_err` never set.
- Non-characters: strobe 1,63,2,40,3 then `rec_done` → `plate_len`=3, stream 1,2,3.
- Overflow: MAX_CHARS=10, strobe 11 valid codes, `rec_done` → `overflow`=1, one-cycle `plate_err`, no `out_valid`, `busy`=0 two cycles after `rec_done`.
- Backpressure: plate 7,8,9 with `out_ready` toggling 0,1,0,0,1,1 → each `out_ch` held while not ready, exactly 3 transfers, `out_last` only with 9.
- Empty and short plate: `rec_done` with no characters → `plate_err`. With `PLATE_LEN_CHECK_EN` and MIN_CHARS=4, a 3-character plate → `plate_err`; without the macro the same plate streams 3 characters.
- Abort and reset: `start` during READOUT after one transfer → `out_valid`=0 next cycle, `plate_len`=0, new plate collected normally. `rst`=0 mid-COLLECT → all outputs at reset values after that edge.

Source files
------------

// File: rtl/plate_char_buffer.sv
// plate_char_buffer: collects recognizer characters into a plate string and streams it out.
// Optional PLATE_LEN_CHECK_EN also rejects plates shorter than MIN_CHARS.
module plate_char_buffer #(
    parameter int MAX_CHARS = 10,
    parameter int CH_W      = 6,
    parameter int MIN_CHARS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CH_W-1:0] ch_in,
    input  logic            ch_valid,
    input  logic            rec_done,
    output logic [CH_W-1:0] out_ch,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic [3:0]      plate_len,
    output logic            plate_err,
    output logic            overflow,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, COLLECT, CHECK, READOUT} state_t;

`ifdef PLATE_LEN_CHECK_EN
    localparam bit LEN_CHECK = 1'b1;
`else
    localparam bit LEN_CHECK = 1'b0;
`endif

    state_t          r_state, w_next;
    logic [CH_W-1:0] r_buf [MAX_CHARS];
    logic [3:0]      r_len, r_rd_ptr;
    logic [CH_W-1:0] r_out_ch;
    logic            r_out_valid, r_out_last, r_plate_err, r_overflow;
    logic            w_ch_ok, w_full, w_wr, w_xfer, w_reject;
    logic [3:0]      w_rd_nxt;

    // codes 36 and above are non-characters and never reach the buffer
    assign w_ch_ok  = ch_valid && (32'(ch_in) < 36);
    assign w_full   = r_len == 4'(MAX_CHARS);
    assign w_wr     = (r_state == COLLECT) && !start && w_ch_ok && !w_full;
    assign w_xfer   = r_out_valid && out_ready;
    assign w_rd_nxt = r_rd_ptr + 4'd1;
    assign w_reject = (r_len == 4'd0) || r_overflow || (LEN_CHECK && (r_len < 4'(MIN_CHARS)));

    always_comb begin
        w_next = r_state;
        if (start)
            w_next = COLLECT;
        else
            case (r_state)
                COLLECT: w_next = rec_done ? CHECK : COLLECT;
                CHECK:   w_next = w_reject ? IDLE : READOUT;
                READOUT: w_next = (w_xfer && r_out_last) ? IDLE : READOUT;
                default: w_next = r_state;
            endcase
    end

    always_ff @(posedge clk)
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;

    always_ff @(posedge clk)
        if (w_wr) r_buf[r_len] <= ch_in;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_len       <= 4'd0;
            r_rd_ptr    <= 4'd0;
            r_overflow  <= 1'b0;
            r_plate_err <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_ch    <= '0;
        end else begin
            r_plate_err <= (r_state == CHECK) && !start && w_reject;
            if (start) begin
                r_len       <= 4'd0;
                r_rd_ptr    <= 4'd0;
                r_overflow  <= 1'b0;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end else
                case (r_state)
                    COLLECT: begin
                        if (w_wr) r_len <= r_len + 4'd1;
                        if (w_ch_ok && w_full) r_overflow <= 1'b1;
                    end
                    CHECK: if (!w_reject) begin
                        r_rd_ptr    <= 4'd0;
                        r_out_valid <= 1'b1;
                        r_out_ch    <= r_buf[0];
                        r_out_last  <= r_len == 4'd1;
                    end
                    READOUT: if (w_xfer) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_rd_ptr   <= w_rd_nxt;
                            r_out_ch   <= r_buf[w_rd_nxt];
                            r_out_last <= w_rd_nxt == r_len - 4'd1;
                        end
                    end
                    default: ;
                endcase
        end
    end

    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign plate_len = r_len;
    assign plate_err = r_plate_err;
    assign overflow  = r_overflow;
    assign busy      = r_state != IDLE;
endmodule

// File: tb/tb_plate_char_buffer.sv
// tb_plate_char_buffer: randomized and directed plates checked against a queue-based plate model.
module tb_plate_char_buffer;
    localparam int MAX  = 10;
    localparam int W    = 6;
    localparam int MINC = 4;

    logic         clk = 0, rst = 0, start = 0, ch_valid = 0, rec_done = 0, out_ready = 0;
    logic [W-1:0] ch_in = '0;
    logic [W-1:0] out_ch;
    logic         out_valid, out_last, plate_err, overflow, busy;
    logic [3:0]   plate_len;
    int           checks = 0, errors = 0;
    int           codes[$];
    bit           rdy[$];

    plate_char_buffer #(.MAX_CHARS(MAX), .CH_W(W), .MIN_CHARS(MINC)) dut (
        .clk(clk), .rst(rst), .start(start), .ch_in(ch_in), .ch_valid(ch_valid),
        .rec_done(rec_done), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .plate_len(plate_len), .plate_err(plate_err),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1;
        tick;
        start = 0;
        chk("start_busy", busy, 1);
        chk("start_len", plate_len, 0);
        chk("start_ovf", overflow, 0);
        chk("start_valid", out_valid, 0);
    endtask

    task automatic collect_and_read(input int cs[$], input bit rq[$], input bit same_done, input bit noise);
        int q[$];
        bit ovf, rej, x;
        int idx, cyc;
        ovf = 0;
        foreach (cs[i]) begin
            ch_in    = W'(cs[i]);
            ch_valid = 1;
            rec_done = same_done && (i == cs.size() - 1);
            if (cs[i] < 36) begin
                if (q.size() < MAX) q.push_back(cs[i]);
                else ovf = 1;
            end
            tick;
            ch_valid = 0;
            rec_done = 0;
            chk("collect_len", plate_len, q.size());
            chk("collect_ovf", overflow, ovf);
            if (!(same_done && i == cs.size() - 1)) repeat ($urandom_range(0, 2)) tick;
        end
        if (!same_done || cs.size() == 0) begin
            rec_done = 1;
            tick;
            rec_done = 0;
        end
        chk("check_valid", out_valid, 0);
        chk("check_err", plate_err, 0);
        chk("check_busy", busy, 1);
        rej = (q.size() == 0) || ovf;
`ifdef PLATE_LEN_CHECK_EN
        rej = rej || (q.size() < MINC);
`endif
        tick;
        chk("plate_err", plate_err, rej);
        chk("first_valid", out_valid, !rej);
        chk("final_len", plate_len, q.size());
        if (rej) begin
            tick;
            chk("err_pulse_end", plate_err, 0);
            chk("err_busy", busy, 0);
            chk("err_valid", out_valid, 0);
            return;
        end
        idx = 0;
        cyc = 0;
        while (idx < q.size() && cyc < 200) begin
            chk("out_valid", out_valid, 1);
            chk("out_ch", out_ch, q[idx]);
            chk("out_last", out_last, idx == q.size() - 1);
            out_ready = (cyc < rq.size()) ? rq[cyc] : 1'b1;
            if (noise) begin
                ch_valid = 1'($urandom);
                rec_done = 1'($urandom);
                ch_in    = W'($urandom);
            end
            x = out_ready;
            tick;
            if (x) idx++;
            cyc++;
        end
        out_ready = 0;
        ch_valid  = 0;
        rec_done  = 0;
        chk("xfer_count", idx, q.size());
        chk("done_valid", out_valid, 0);
        chk("done_busy", busy, 0);
        chk("len_hold", plate_len, q.size());
    endtask

    initial begin
        repeat (2) tick;
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_ch", out_ch, 0);
        chk("rst_len", plate_len, 0);
        chk("rst_err", plate_err, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);
        rst = 1;
        tick;

        rdy.delete();
        codes = '{10, 11, 3, 4, 5, 6};
        do_start;
        collect_and_read(codes, rdy, 0, 0);

        codes = '{1, 63, 2, 40, 3};
        do_start;
        collect_and_read(codes, rdy, 1, 0);

        codes = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 35};
        do_start;
        collect_and_read(codes, rdy, 0, 0);

        codes = '{7, 8, 9};
        rdy   = '{0, 1, 0, 0, 1, 1};
        do_start;
        collect_and_read(codes, rdy, 0, 0);
        rdy.delete();

        codes.delete();
        do_start;
        collect_and_read(codes, rdy, 0, 0);

        codes = '{20, 21, 22};
        do_start;
        collect_and_read(codes, rdy, 0, 0);

        // abort during readout after one transfer
        do_start;
        foreach (codes[i]) begin
            ch_in = W'(codes[i]);
            ch_valid = 1;
            tick;
        end
        ch_valid = 0;
        rec_done = 1;
        tick;
        rec_done = 0;
        tick;
        if (out_valid) begin
            out_ready = 1;
            chk("abort_ch0", out_ch, 20);
            tick;
            out_ready = 0;
            chk("abort_ch1", out_ch, 21);
            start = 1;
            tick;
            start = 0;
            chk("abort_valid", out_valid, 0);
            chk("abort_len", plate_len, 0);
            chk("abort_busy", busy, 1);
            chk("abort_err", plate_err, 0);
            codes = '{12, 13, 14, 15};
            collect_and_read(codes, rdy, 0, 0);
        end

        // reset in the middle of collection
        do_start;
        ch_in = 5;
        ch_valid = 1;
        tick;
        ch_in = 6;
        rst = 0;
        tick;
        ch_valid = 0;
        rst = 1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_ch", out_ch, 0);
        chk("mid_rst_len", plate_len, 0);
        chk("mid_rst_err", plate_err, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_busy", busy, 0);
        codes = '{30, 31, 32, 33, 34};
        do_start;
        collect_and_read(codes, rdy, 0, 0);

        for (int p = 0; p < 30; p++) begin
            codes.delete();
            rdy.delete();
            repeat ($urandom_range(0, 13))
                codes.push_back(($urandom % 10 < 7) ? $urandom_range(0, 35) : $urandom_range(36, 63));
            repeat (40) rdy.push_back(1'($urandom));
            do_start;
            collect_and_read(codes, rdy, 1'($urandom), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
